// File: rtl/operand_pair_sequencer_if.sv
// Bundle-in / pair-out bus of operand_pair_sequencer.
// slave is the sequencer side; master is the matcher/MAC side that drives it.
interface operand_pair_sequencer_if #(
    parameter int BITMASK_LENGTH = 8,
    parameter int INDEX_BITWIDTH = 3,
    parameter int VALUE_BITWIDTH = 8
);
    logic                                     ivalid;
    logic                                     oready;
    logic [63:0]                              matchResult;
    logic [BITMASK_LENGTH*VALUE_BITWIDTH-1:0] valuesA;
    logic [BITMASK_LENGTH*VALUE_BITWIDTH-1:0] valuesW;
    logic                                     ovalid;
    logic                                     iready;
    logic [VALUE_BITWIDTH-1:0]                operandA;
    logic [VALUE_BITWIDTH-1:0]                operandW;
    logic [INDEX_BITWIDTH-1:0]                pairIndex;
    logic                                     olast;
    logic                                     oempty;

    modport slave (
        input  ivalid, matchResult, valuesA, valuesW, iready,
        output oready, ovalid, operandA, operandW, pairIndex, olast, oempty
    );

    modport master (
        output ivalid, matchResult, valuesA, valuesW, iready,
        input  oready, ovalid, operandA, operandW, pairIndex, olast, oempty
    );
endinterface

// File: rtl/operand_pair_sequencer.sv
// Serialises the matched (activation, weight) pairs of one packed match word, one pair per handshake.
// Optional macro OPERAND_PAIR_SEQUENCER_EMPTY_MARKER_EN: emit one oempty/olast beat for count==0 bundles.
module operand_pair_sequencer #(
    parameter int BITMASK_LENGTH = 8,
    parameter int INDEX_BITWIDTH = 3,
    parameter int COUNT_BITWIDTH = 4,
    parameter int VALUE_BITWIDTH = 8
) (
    input logic                     clock,
    input logic                     resetn,
    operand_pair_sequencer_if.slave bus
);
    localparam int IDX_FIELD_W = BITMASK_LENGTH * INDEX_BITWIDTH;
    localparam int CNT_LSB     = 2 * IDX_FIELD_W;
    localparam int VEC_W       = BITMASK_LENGTH * VALUE_BITWIDTH;
    localparam logic [COUNT_BITWIDTH-1:0] MAX_COUNT = COUNT_BITWIDTH'(BITMASK_LENGTH);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_FIELD_W-1:0]    idx_a_q, idx_a_d;
    logic [IDX_FIELD_W-1:0]    idx_w_q, idx_w_d;
    logic [VEC_W-1:0]          vals_a_q, vals_a_d;
    logic [VEC_W-1:0]          vals_w_q, vals_w_d;
    logic [COUNT_BITWIDTH-1:0] count_q, count_d;
    logic [INDEX_BITWIDTH-1:0] k_q, k_d, k_inc;
    logic [VALUE_BITWIDTH-1:0] op_a_q, op_a_d;
    logic [VALUE_BITWIDTH-1:0] op_w_q, op_w_d;
    logic                      last_q, last_d;
`ifdef OPERAND_PAIR_SEQUENCER_EMPTY_MARKER_EN
    logic                      empty_q, empty_d;
`endif

    logic [COUNT_BITWIDTH-1:0] count_raw, count_in;
    logic                      accept;
    logic                      start_bundle;
    logic                      unused_match_bits;

    // Entry idx[k] of a compressed value vector.
    function automatic logic [VALUE_BITWIDTH-1:0] pick_value(
        input logic [VEC_W-1:0]          vec,
        input logic [IDX_FIELD_W-1:0]    idx,
        input logic [INDEX_BITWIDTH-1:0] k
    );
        logic [INDEX_BITWIDTH-1:0] entry;
        entry = idx[int'(k)*INDEX_BITWIDTH +: INDEX_BITWIDTH];
        return vec[int'(entry)*VALUE_BITWIDTH +: VALUE_BITWIDTH];
    endfunction

    function automatic logic is_last(
        input logic [INDEX_BITWIDTH-1:0] k,
        input logic [COUNT_BITWIDTH-1:0] count
    );
        return COUNT_BITWIDTH'(k) == (count - COUNT_BITWIDTH'(1));
    endfunction

    assign count_raw         = bus.matchResult[CNT_LSB +: COUNT_BITWIDTH];
    assign count_in          = (count_raw > MAX_COUNT) ? MAX_COUNT : count_raw;
    assign unused_match_bits = ^bus.matchResult[63:CNT_LSB+COUNT_BITWIDTH];
    assign k_inc             = k_q + 1'b1;

    // A new bundle may land on the same edge the last beat leaves, so oready follows iready directly.
    assign bus.oready = (state_q == IDLE) || ((state_q == ISSUE) && last_q && bus.iready);
    assign accept     = bus.ivalid && bus.oready;

    always_comb begin
        // NOTE: every next value defaults to a hold first, so no path through this block infers a latch.
        state_d      = state_q;
        idx_a_d      = idx_a_q;
        idx_w_d      = idx_w_q;
        vals_a_d     = vals_a_q;
        vals_w_d     = vals_w_q;
        count_d      = count_q;
        k_d          = k_q;
        op_a_d       = op_a_q;
        op_w_d       = op_w_q;
        last_d       = last_q;
`ifdef OPERAND_PAIR_SEQUENCER_EMPTY_MARKER_EN
        empty_d      = empty_q && !bus.iready;
`endif
        start_bundle = 1'b0;

        case (state_q)
            IDLE: start_bundle = accept;
            ISSUE: begin
                if (bus.iready) begin
                    if (!last_q) begin
                        k_d    = k_inc;
                        op_a_d = pick_value(vals_a_q, idx_a_q, k_inc);
                        op_w_d = pick_value(vals_w_q, idx_w_q, k_inc);
                        last_d = is_last(k_inc, count_q);
                    end else if (accept) begin
                        start_bundle = 1'b1;
                    end else begin
                        state_d = IDLE;
                        k_d     = '0;
                        op_a_d  = '0;
                        op_w_d  = '0;
                        last_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Pair 0 comes straight off the inputs so the first beat follows the accept edge.
        if (start_bundle) begin
            idx_a_d  = bus.matchResult[0 +: IDX_FIELD_W];
            idx_w_d  = bus.matchResult[IDX_FIELD_W +: IDX_FIELD_W];
            vals_a_d = bus.valuesA;
            vals_w_d = bus.valuesW;
            count_d  = count_in;
            k_d      = '0;
            if (count_in != '0) begin
                state_d = ISSUE;
                op_a_d  = pick_value(bus.valuesA, idx_a_d, '0);
                op_w_d  = pick_value(bus.valuesW, idx_w_d, '0);
                last_d  = (count_in == COUNT_BITWIDTH'(1));
            end else begin
`ifdef OPERAND_PAIR_SEQUENCER_EMPTY_MARKER_EN
                state_d = ISSUE;
                op_a_d  = '0;
                op_w_d  = '0;
                last_d  = 1'b1;
                empty_d = 1'b1;
`else
                state_d = IDLE;
                op_a_d  = '0;
                op_w_d  = '0;
                last_d  = 1'b0;
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            // NOTE: the bundle registers are reset too, so nothing undefined reaches the operand path.
            idx_a_q  <= '0;
            idx_w_q  <= '0;
            vals_a_q <= '0;
            vals_w_q <= '0;
            count_q  <= '0;
            k_q      <= '0;
            op_a_q   <= '0;
            op_w_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_a_q  <= idx_a_d;
            idx_w_q  <= idx_w_d;
            vals_a_q <= vals_a_d;
            vals_w_q <= vals_w_d;
            count_q  <= count_d;
            k_q      <= k_d;
            op_a_q   <= op_a_d;
            op_w_q   <= op_w_d;
            last_q   <= last_d;
        end
    end

`ifdef OPERAND_PAIR_SEQUENCER_EMPTY_MARKER_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            empty_q <= 1'b0;
        end else begin
            empty_q <= empty_d;
        end
    end

    assign bus.oempty = empty_q;
`else
    assign bus.oempty = 1'b0;
`endif

    assign bus.ovalid    = (state_q == ISSUE);
    assign bus.operandA  = op_a_q;
    assign bus.operandW  = op_w_q;
    assign bus.pairIndex = k_q;
    assign bus.olast     = last_q;
endmodule

// File: tb/tb_operand_pair_sequencer.sv
// Directed bench for operand_pair_sequencer: reset, streaming, backpressure, back-to-back,
// count clamp, empty bundle and asynchronous reset in the middle of a bundle.
module tb_operand_pair_sequencer;
    localparam int BL = 8;
    localparam int IW = 3;
    localparam int CW = 4;
    localparam int VW = 8;

    localparam logic [63:0] VALS_A   = 64'h1716_1514_1312_1110;
    localparam logic [63:0] VALS_W   = 64'h2726_2524_2322_2120;
    localparam logic [63:0] MR_THREE = 64'h0003_0001_1000_0159;  // A idx 1,3,5  W idx 0,2,4
    localparam logic [63:0] MR_ONE77 = 64'h0001_0000_0700_0007;  // one pair, A idx 7, W idx 7
    localparam logic [63:0] MR_CLAMP = 64'hABCF_FAC6_88FA_C688;  // count 15, idx k = k, junk on top
    localparam logic [63:0] MR_EMPTY = 64'hFFF0_0000_0000_0159;  // count 0, junk on top

    logic clock  = 1'b0;
    logic resetn = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    operand_pair_sequencer_if #(
        .BITMASK_LENGTH(BL),
        .INDEX_BITWIDTH(IW),
        .VALUE_BITWIDTH(VW)
    ) bus ();

    operand_pair_sequencer #(
        .BITMASK_LENGTH(BL),
        .INDEX_BITWIDTH(IW),
        .COUNT_BITWIDTH(CW),
        .VALUE_BITWIDTH(VW)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input string tag, input logic [7:0] a, input logic [7:0] w,
                               input logic [2:0] k, input logic last, input logic empty);
        check({tag, ".ovalid"},    64'(bus.ovalid),    64'(1'b1));
        check({tag, ".operandA"},  64'(bus.operandA),  64'(a));
        check({tag, ".operandW"},  64'(bus.operandW),  64'(w));
        check({tag, ".pairIndex"}, 64'(bus.pairIndex), 64'(k));
        check({tag, ".olast"},     64'(bus.olast),     64'(last));
        check({tag, ".oempty"},    64'(bus.oempty),    64'(empty));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".ovalid"}, 64'(bus.ovalid), 64'(1'b0));
        check({tag, ".oready"}, 64'(bus.oready), 64'(1'b1));
        check({tag, ".olast"},  64'(bus.olast),  64'(1'b0));
    endtask

    task automatic send(input logic [63:0] mr);
        bus.ivalid      = 1'b1;
        bus.matchResult = mr;
        bus.valuesA     = VALS_A;
        bus.valuesW     = VALS_W;
    endtask

    initial begin
        logic [7:0] ea;
        logic [7:0] ew;
        bus.ivalid      = 1'b0;
        bus.iready      = 1'b0;
        bus.matchResult = '0;
        bus.valuesA     = '0;
        bus.valuesW     = '0;

        // Reset asserted before the first clock edge: outputs must settle with no edge.
        #3 resetn = 1'b0;
        #1;
        check("rst.ovalid",    64'(bus.ovalid),    64'(1'b0));
        check("rst.oready",    64'(bus.oready),    64'(1'b1));
        check("rst.operandA",  64'(bus.operandA),  64'(8'h00));
        check("rst.operandW",  64'(bus.operandW),  64'(8'h00));
        check("rst.pairIndex", 64'(bus.pairIndex), 64'(3'd0));
        check("rst.olast",     64'(bus.olast),     64'(1'b0));
        check("rst.oempty",    64'(bus.oempty),    64'(1'b0));
        tick();
        tick();
        resetn = 1'b1;

        // Three-pair bundle streamed with iready held high.
        send(MR_THREE);
        bus.iready = 1'b1;
        check("b.accept.oready", 64'(bus.oready), 64'(1'b1));
        tick();
        bus.ivalid = 1'b0;
        expect_beat("b0", 8'h11, 8'h20, 3'd0, 1'b0, 1'b0);
        check("b0.oready", 64'(bus.oready), 64'(1'b0));
        tick();
        expect_beat("b1", 8'h13, 8'h22, 3'd1, 1'b0, 1'b0);
        tick();
        expect_beat("b2", 8'h15, 8'h24, 3'd2, 1'b1, 1'b0);
        check("b2.oready", 64'(bus.oready), 64'(1'b1));
        tick();
        expect_idle("b.end");

        // Backpressure on beat 1; the next bundle waits on ivalid while the sequencer is busy.
        send(MR_THREE);
        tick();
        bus.ivalid = 1'b0;
        expect_beat("c0", 8'h11, 8'h20, 3'd0, 1'b0, 1'b0);
        tick();
        expect_beat("c1", 8'h13, 8'h22, 3'd1, 1'b0, 1'b0);
        bus.iready = 1'b0;
        send(MR_ONE77);
        check("c1.busy.oready", 64'(bus.oready), 64'(1'b0));
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_beat("c1.hold", 8'h13, 8'h22, 3'd1, 1'b0, 1'b0);
            check("c1.hold.oready", 64'(bus.oready), 64'(1'b0));
        end
        bus.iready = 1'b1;
        tick();
        expect_beat("c2", 8'h15, 8'h24, 3'd2, 1'b1, 1'b0);
        check("c2.b2b.oready", 64'(bus.oready), 64'(1'b1));

        // Back-to-back: the held bundle is taken on the last beat, no bubble.
        tick();
        bus.ivalid = 1'b0;
        expect_beat("d0", 8'h17, 8'h27, 3'd0, 1'b1, 1'b0);
        tick();
        expect_idle("d.end");

        // Count field 15 clamps to 8 beats; upper junk bits ignored.
        send(MR_CLAMP);
        tick();
        bus.ivalid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ea = 8'(8'h10 + k);
            ew = 8'(8'h20 + k);
            expect_beat("e", ea, ew, 3'(k), (k == 7), 1'b0);
            tick();
        end
        expect_idle("e.end");

        // Empty bundle.
        send(MR_EMPTY);
        tick();
        bus.ivalid = 1'b0;
`ifdef OPERAND_PAIR_SEQUENCER_EMPTY_MARKER_EN
        expect_beat("f.marker", 8'h00, 8'h00, 3'd0, 1'b1, 1'b1);
        check("f.marker.oready", 64'(bus.oready), 64'(1'b1));
        tick();
        expect_idle("f.end");
        check("f.end.oempty", 64'(bus.oempty), 64'(1'b0));
`else
        expect_idle("f.silent");
        check("f.silent.oempty", 64'(bus.oempty), 64'(1'b0));
        tick();
        expect_idle("f.end");
`endif

        // Asynchronous reset during beat 1, then a clean restart.
        send(MR_THREE);
        tick();
        bus.ivalid = 1'b0;
        expect_beat("g0", 8'h11, 8'h20, 3'd0, 1'b0, 1'b0);
        tick();
        expect_beat("g1", 8'h13, 8'h22, 3'd1, 1'b0, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check("g.rst.ovalid",    64'(bus.ovalid),    64'(1'b0));
        check("g.rst.oready",    64'(bus.oready),    64'(1'b1));
        check("g.rst.pairIndex", 64'(bus.pairIndex), 64'(3'd0));
        check("g.rst.operandA",  64'(bus.operandA),  64'(8'h00));
        check("g.rst.olast",     64'(bus.olast),     64'(1'b0));
        tick();
        tick();
        resetn = 1'b1;
        send(MR_THREE);
        tick();
        bus.ivalid = 1'b0;
        expect_beat("g.r0", 8'h11, 8'h20, 3'd0, 1'b0, 1'b0);
        tick();
        expect_beat("g.r1", 8'h13, 8'h22, 3'd1, 1'b0, 1'b0);
        tick();
        expect_beat("g.r2", 8'h15, 8'h24, 3'd2, 1'b1, 1'b0);
        tick();
        expect_idle("g.end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/operand_pair_sequencer.md
Name: operand_pair_sequencer

Overview:
- Consumes the 64-bit packed match word produced by the operand matcher: per-pair activation indices, per-pair weight indices, and the pair count.
- Also consumes the two compressed non-zero value vectors that the match word indexes.
- Serialises the matched pairs, one (activation, weight) operand pair per handshake, to the downstream MAC lane.
- Sits between the operand matcher and the PE multiplier, and is the reader of the matcher's packed result format.

Parameters:
- BITMASK_LENGTH, 8, number of lanes per bitmask and maximum pairs per bundle.
- INDEX_BITWIDTH, 3, width of each packed index field.
- COUNT_BITWIDTH, 4, width of the pair-count field.
- VALUE_BITWIDTH, 8, width of one compressed operand value.

Ports:
- clock, input, 1, sole clock.
- resetn, input, 1, asynchronous active-low reset.
- ivalid, input, 1, upstream bundle valid.
- oready, output, 1, sequencer can accept a bundle.
- matchResult, input, 64, [23:0] activation index k at [3k+2:3k]; [47:24] weight index k at [24+3k+2:24+3k]; [51:48] pair count; [63:52] ignored.
- valuesA, input, BITMASK_LENGTH*VALUE_BITWIDTH, compressed activation values; entry j at [8j+7:8j].
- valuesW, input, BITMASK_LENGTH*VALUE_BITWIDTH, compressed weight values, same layout.
- ovalid, output, 1, output pair valid.
- iready, input, 1, downstream accepts the pair.
- operandA, output, VALUE_BITWIDTH, activation value of the current pair.
- operandW, output, VALUE_BITWIDTH, weight value of the current pair.
- pairIndex, output, INDEX_BITWIDTH, ordinal k of the current pair within its bundle.
- olast, output, 1, current pair is the last of its bundle.
- oempty, output, 1, empty-bundle marker (see Optional Feature).

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-low on `resetn`.
- Reset state: state=IDLE. oready=1. ovalid, olast and oempty=0. operandA, operandW and pairIndex=0. Bundle registers cleared.
- Bundle accept: a bundle is accepted when ivalid&oready. matchResult, valuesA and valuesW are all latched on that edge.
- Count clamping: count = min(matchResult[51:48], BITMASK_LENGTH). Values 9..15 clamp to 8.
- IDLE state:
  - oready=1.
  - On accept with count>0: go to ISSUE, k=0, and load the output registers for pair 0.
  - On accept with count==0: no beat is produced (see Optional Feature); stay in IDLE.
- ISSUE state:
  - ovalid=1.
  - Output registers hold pair k:
    - operandA = valuesA entry at idxA[k].
    - operandW = valuesW entry at idxW[k].
    - pairIndex = k.
    - olast = (k==count-1).
  - Outputs hold stable while ovalid&!iready.
  - On iready with !olast: k<=k+1 and registers reload for pair k+1.
  - On iready with olast: bundle is done.
- Back-to-back bundles: oready = IDLE | (ISSUE & olast & iready). This is combinational from iready.
  - A new bundle accepted on the same edge as the last beat loads pair 0 of the new bundle next cycle, with no bubble.
  - If no bundle arrives, the next state is IDLE and ovalid=0.
- Timing:
  - Latency is one cycle: accept at edge t gives the first pair valid after edge t.
  - Throughput is one pair per cycle while iready=1.
- Index fields are used verbatim. An index may exceed count-1 in the value vectors; no range check is made.
- Reset mid-bundle: remaining pairs are discarded and the state returns to IDLE immediately (asynchronous).
- ivalid while busy is ignored, since oready=0; the upstream holds the bundle.

Optional Feature:
- Macro: OPERAND_PAIR_SEQUENCER_EMPTY_MARKER_EN.
- Defined: a count==0 bundle enters ISSUE and emits exactly one beat with ovalid=1, olast=1, oempty=1, operandA=0, operandW=0 and pairIndex=0. This lets the downstream close the bundle. oempty=0 on all normal beats.
- Undefined: a count==0 bundle is consumed silently in IDLE, and oempty is tied to 0.

Test Plan:
- Reset then idle: reset asserted mid-simulation → ovalid=0, oready=1, all outputs 0, with no clock edge required.
- Three-pair bundle:
  - Stimulus: matchResult=64'h0003_0001_1000_0159; valuesA byte j=8'h10+j; valuesW byte j=8'h20+j; iready=1.
  - Response: beats (11,20,k0), (13,22,k1), (15,24,k2,olast=1) on consecutive cycles, starting 1 cycle after accept.
- Backpressure: same bundle with iready=0 for 3 cycles on beat 1 → operandA=8'h13 and operandW=8'h22 held stable. Then beat 2 follows the first iready=1 cycle; no beat is dropped or duplicated.
- Back-to-back: second bundle with count=1 and A0=7, W0=7 held on ivalid during the first bundle's last beat → oready=1 on that cycle. Next cycle gives (17,27,olast=1) with no idle gap.
- Count clamp and empty:
  - count field=4'hF with all indices k → exactly 8 beats, olast on k=7.
  - count=0 → no beat without the macro; one oempty/olast beat with the macro.
- Reset mid-bundle: resetn low during beat 1 of a 3-pair bundle → ovalid drops immediately. After release the next bundle starts cleanly at k=0.
